cpu_bus_fabric: RTL and testbench



---
 rtl/cpu_bus_fabric.sv | 165 ++++++++++++++++
 tb/tb_cpu_bus_fabric.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_fabric.sv
// cpu_bus_fabric
// CPU-side bus fabric: priority read-data mux over enable-qualified slaves
// with RAM fallback, plus a page-to-register sprite DMA engine that halts
// the CPU through RDY.
//
// Ports
//   cpu_clk_in        CPU clock, all state on rising edge
//   rst_n_in          synchronous active-low reset
//   cpu_read_in       CPU read strobe
//   cpu_write_in      CPU write strobe
//   cpu_address_in    CPU address
//   cpu_data_in       CPU write data
//   slave_data_en_in  per-slave read-data valid (bit 0 highest priority)
//   slave_data_in     packed slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ram_data_in       RAM read data, used when no slave enable is high
//   cpu_data_out      read data to CPU
//   bus_read_out      read strobe to slaves/RAM
//   bus_write_out     write strobe to slaves/RAM
//   bus_address_out   address to slaves/RAM
//   bus_data_out      write data to slaves/RAM
//   cpu_rdy_out       CPU ready, low while DMA owns the bus
//   dma_active_out    high whenever the DMA engine is not idle
//
// state | meaning
// IDLE  | CPU owns the bus, strobes/address/data pass straight through
// HALT  | first DMA cycle, CPU stalled, bus quiet
// ALIGN | extra quiet cycle so every READ lands on parity 0
// READ  | read source byte at {page, index}, latch it at the edge
// WRITE | write latched byte to DMA_DEST_ADDR, advance or finish
module cpu_bus_fabric #(
    parameter int                    NUM_SLAVES    = 4,
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    ADDR_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [ADDR_WIDTH-1:0] DMA_DEST_ADDR = 16'h2004,
    parameter int                    DMA_LENGTH    = 256
) (
    input  logic                             cpu_clk_in,
    input  logic                             rst_n_in,
    input  logic                             cpu_read_in,
    input  logic                             cpu_write_in,
    input  logic [ADDR_WIDTH-1:0]            cpu_address_in,
    input  logic [DATA_WIDTH-1:0]            cpu_data_in,
    input  logic [NUM_SLAVES-1:0]            slave_data_en_in,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_data_in,
    input  logic [DATA_WIDTH-1:0]            ram_data_in,
    output logic [DATA_WIDTH-1:0]            cpu_data_out,
    output logic                             bus_read_out,
    output logic                             bus_write_out,
    output logic [ADDR_WIDTH-1:0]            bus_address_out,
    output logic [DATA_WIDTH-1:0]            bus_data_out,
    output logic                             cpu_rdy_out,
    output logic                             dma_active_out
);

    localparam int IDX_W = (DMA_LENGTH > 1) ? $clog2(DMA_LENGTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DMA_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t                  state_q, state_d;
    logic                    parity_q;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [7:0]              page_q, page_d;
    logic [DATA_WIDTH-1:0]   latch_q, latch_d;
    logic [DATA_WIDTH-1:0]   mux_data;
    logic [15:0]             dma_src;
    logic                    trigger;

    // Walk from lowest priority to highest so the lowest enabled index wins.
    always_comb begin
        mux_data = ram_data_in;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (slave_data_en_in[i]) begin
                mux_data = slave_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign cpu_data_out = mux_data;

    // Index is zero-extended into the low byte so it never reaches the page.
    assign dma_src = {page_q, 8'(index_q)};
    assign trigger = cpu_write_in && (cpu_address_in == DMA_REG_ADDR);

    always_ff @(posedge cpu_clk_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            parity_q <= 1'b0;
            index_q  <= '0;
            page_q   <= '0;
            latch_q  <= '0;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            index_q  <= index_d;
            page_q   <= page_d;
            latch_q  <= latch_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        index_d         = index_q;
        page_d          = page_q;
        latch_d         = latch_q;
        bus_read_out    = 1'b0;
        bus_write_out   = 1'b0;
        bus_address_out = '0;
        bus_data_out    = '0;
        cpu_rdy_out     = 1'b0;
        dma_active_out  = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                cpu_rdy_out     = 1'b1;
                dma_active_out  = 1'b0;
                bus_read_out    = cpu_read_in;
                bus_write_out   = cpu_write_in;
                bus_address_out = cpu_address_in;
                bus_data_out    = cpu_data_in;
                if (trigger) begin
                    page_d  = cpu_data_in[7:0];
                    index_d = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // Parity flips at this edge, so parity 1 now means READ on parity 0.
                state_d = parity_q ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                bus_read_out    = 1'b1;
                bus_address_out = ADDR_WIDTH'(dma_src);
                latch_d         = mux_data;
                state_d         = S_WRITE;
            end
            S_WRITE: begin
                bus_write_out   = 1'b1;
                bus_address_out = DMA_DEST_ADDR;
                bus_data_out    = latch_q;
                if (index_q == IDX_LAST) begin
                    index_d = '0;
                    state_d = S_IDLE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_bus_fabric.sv
module tb_cpu_bus_fabric;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_dat = '0;
    logic [3:0]  slv_en = '0;
    logic [31:0] slv_dat = '0;
    logic        ram_ovr_en = 1'b0;
    logic [7:0]  ram_ovr = '0;

    logic [7:0]  ram_w      [2];
    logic [7:0]  cpu_data_w [2];
    logic        bus_rd_w   [2];
    logic        bus_wr_w   [2];
    logic [15:0] bus_addr_w [2];
    logic [7:0]  bus_dat_w  [2];
    logic        rdy_w      [2];
    logic        act_w      [2];

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    // Source memory contents seen by the DMA, a fixed function of address.
    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign ram_w[0] = ram_ovr_en ? ram_ovr : mem(bus_addr_w[0]);
    assign ram_w[1] = ram_ovr_en ? ram_ovr : mem(bus_addr_w[1]);

    cpu_bus_fabric u_dut_full (
        .cpu_clk_in      (clk),
        .rst_n_in        (rst_n),
        .cpu_read_in     (cpu_rd),
        .cpu_write_in    (cpu_wr),
        .cpu_address_in  (cpu_addr),
        .cpu_data_in     (cpu_dat),
        .slave_data_en_in(slv_en),
        .slave_data_in   (slv_dat),
        .ram_data_in     (ram_w[0]),
        .cpu_data_out    (cpu_data_w[0]),
        .bus_read_out    (bus_rd_w[0]),
        .bus_write_out   (bus_wr_w[0]),
        .bus_address_out (bus_addr_w[0]),
        .bus_data_out    (bus_dat_w[0]),
        .cpu_rdy_out     (rdy_w[0]),
        .dma_active_out  (act_w[0])
    );

    cpu_bus_fabric #(.DMA_LENGTH(4)) u_dut_short (
        .cpu_clk_in      (clk),
        .rst_n_in        (rst_n),
        .cpu_read_in     (cpu_rd),
        .cpu_write_in    (cpu_wr),
        .cpu_address_in  (cpu_addr),
        .cpu_data_in     (cpu_dat),
        .slave_data_en_in(slv_en),
        .slave_data_in   (slv_dat),
        .ram_data_in     (ram_w[1]),
        .cpu_data_out    (cpu_data_w[1]),
        .bus_read_out    (bus_rd_w[1]),
        .bus_write_out   (bus_wr_w[1]),
        .bus_address_out (bus_addr_w[1]),
        .bus_data_out    (bus_dat_w[1]),
        .cpu_rdy_out     (rdy_w[1]),
        .dma_active_out  (act_w[1])
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t got %0h want %0h", name, inst, $time, act, exp);
        end
    endtask

    // Model: a DMA is a run of cycles counted from the trigger edge.
    // Cycle 0 is the halt, an optional alignment cycle follows, then
    // read/write pairs alternate for each of the LEN bytes.
    int         len_m  [2] = '{256, 4};
    bit         busy_m [2] = '{0, 0};
    int         k_m    [2] = '{0, 0};
    int         align_m[2] = '{0, 0};
    logic [7:0] page_m [2] = '{8'h00, 8'h00};
    bit         par_m = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                busy_m[i] = 1'b0;
            end else if (busy_m[i]) begin
                if (k_m[i] == 2 * len_m[i] + align_m[i]) busy_m[i] = 1'b0;
                else k_m[i]++;
            end else if (cpu_wr && cpu_addr == 16'h4014) begin
                busy_m[i]  = 1'b1;
                k_m[i]     = 0;
                page_m[i]  = cpu_dat;
                // Halt cycle parity is the flipped current parity; align when that is 0.
                align_m[i] = par_m ? 1 : 0;
            end
        end
        par_m = rst_n ? ~par_m : 1'b0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [7:0] exp_mux;
                int j;
                exp_mux = ram_w[i];
                for (int s = 3; s >= 0; s--) if (slv_en[s]) exp_mux = slv_dat[s*8 +: 8];
                chk("cpu_data", i, 32'(cpu_data_w[i]), 32'(exp_mux));
                if (!busy_m[i]) begin
                    chk("rdy", i, 32'(rdy_w[i]), 32'd1);
                    chk("active", i, 32'(act_w[i]), 32'd0);
                    chk("pt_read", i, 32'(bus_rd_w[i]), 32'(cpu_rd));
                    chk("pt_write", i, 32'(bus_wr_w[i]), 32'(cpu_wr));
                    chk("pt_addr", i, 32'(bus_addr_w[i]), 32'(cpu_addr));
                    chk("pt_data", i, 32'(bus_dat_w[i]), 32'(cpu_dat));
                end else begin
                    chk("rdy", i, 32'(rdy_w[i]), 32'd0);
                    chk("active", i, 32'(act_w[i]), 32'd1);
                    j = k_m[i] - 1 - align_m[i];
                    if (j < 0) begin
                        chk("quiet_read", i, 32'(bus_rd_w[i]), 32'd0);
                        chk("quiet_write", i, 32'(bus_wr_w[i]), 32'd0);
                    end else if (j % 2 == 0) begin
                        chk("dma_read", i, 32'(bus_rd_w[i]), 32'd1);
                        chk("dma_rwrite", i, 32'(bus_wr_w[i]), 32'd0);
                        chk("dma_src", i, 32'(bus_addr_w[i]), 32'({page_m[i], 8'(j / 2)}));
                    end else begin
                        chk("dma_wread", i, 32'(bus_rd_w[i]), 32'd0);
                        chk("dma_write", i, 32'(bus_wr_w[i]), 32'd1);
                        chk("dma_dst", i, 32'(bus_addr_w[i]), 32'h2004);
                        chk("dma_data", i, 32'(bus_dat_w[i]), 32'(mem({page_m[i], 8'(j / 2)})));
                    end
                end
            end
        end
    end

    // Trigger so that the halt cycle lands on the requested parity.
    task automatic trigger(input logic [7:0] pg, input bit halt_par);
        @(posedge clk); #1;
        if (par_m == halt_par) begin
            @(posedge clk); #1;
        end
        cpu_wr = 1'b1; cpu_addr = 16'h4014; cpu_dat = pg;
        @(posedge clk); #1;
        cpu_wr = 1'b0; cpu_addr = '0; cpu_dat = '0;
    endtask

    task automatic measure(input int inst, output int cnt, output logic [15:0] first_a, output logic [15:0] last_a);
        bit seen;
        bit done;
        seen = 0; done = 0; cnt = 0; first_a = '0; last_a = '0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (rdy_w[inst]) begin
                done = 1;
            end else begin
                cnt++;
                if (bus_rd_w[inst]) begin
                    if (!seen) first_a = bus_addr_w[inst];
                    seen = 1;
                    last_a = bus_addr_w[inst];
                end
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL rdy_timeout[%0d] still low after 2000 cycles", inst);
        end
    endtask

    int c0, c1;
    logic [15:0] f0, l0, f1, l1;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_rdy", 0, 32'(rdy_w[0]), 32'd1);
        chk("reset_active", 0, 32'(act_w[0]), 32'd0);

        // Read priority
        @(posedge clk); #1;
        slv_en = 4'b0110; slv_dat = 32'h00B2A100;
        @(negedge clk);
        chk("prio_a1", 0, 32'(cpu_data_w[0]), 32'hA1);
        @(posedge clk); #1;
        slv_en = 4'b1111; slv_dat = 32'hD4C3B2A1;
        @(negedge clk);
        chk("prio_s0", 1, 32'(cpu_data_w[1]), 32'hA1);
        @(posedge clk); #1;
        slv_en = 4'b1000;
        @(negedge clk);
        chk("prio_s3", 0, 32'(cpu_data_w[0]), 32'hD4);
        @(posedge clk); #1;
        slv_en = 4'b0000; ram_ovr_en = 1'b1; ram_ovr = 8'h5C;
        @(negedge clk);
        chk("prio_ram", 0, 32'(cpu_data_w[0]), 32'h5C);
        @(posedge clk); #1;
        ram_ovr_en = 1'b0; slv_dat = '0;
        cpu_rd = 1'b1; cpu_addr = 16'h0123;
        @(negedge clk);
        chk("pt_addr_lit", 0, 32'(bus_addr_w[0]), 32'h0123);
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_addr = '0;

        // Halt on parity 1: no alignment cycle
        trigger(8'h02, 1'b1);
        fork
            measure(0, c0, f0, l0);
            measure(1, c1, f1, l1);
        join
        chk("even_len", 0, 32'(c0), 32'd513);
        chk("even_first", 0, 32'(f0), 32'h0200);
        chk("even_last", 0, 32'(l0), 32'h02FF);
        chk("even_len", 1, 32'(c1), 32'd9);
        chk("even_first", 1, 32'(f1), 32'h0200);
        chk("even_last", 1, 32'(l1), 32'h0203);

        // Halt on parity 0: one alignment cycle
        repeat (3) @(posedge clk);
        trigger(8'h07, 1'b0);
        fork
            measure(0, c0, f0, l0);
            measure(1, c1, f1, l1);
        join
        chk("odd_len", 0, 32'(c0), 32'd514);
        chk("odd_first", 0, 32'(f0), 32'h0700);
        chk("odd_len", 1, 32'(c1), 32'd10);
        chk("odd_first", 1, 32'(f1), 32'h0700);
        chk("odd_last", 1, 32'(l1), 32'h0703);

        // Trigger write during an active DMA is ignored
        repeat (2) @(posedge clk);
        trigger(8'h05, 1'b1);
        fork
            measure(0, c0, f0, l0);
            begin
                repeat (50) @(posedge clk);
                #1 cpu_wr = 1'b1; cpu_addr = 16'h4014; cpu_dat = 8'h09;
                @(posedge clk);
                #1 cpu_wr = 1'b0; cpu_addr = '0; cpu_dat = '0;
            end
        join
        chk("ignore_len", 0, 32'(c0), 32'd513);
        chk("ignore_last", 0, 32'(l0), 32'h05FF);

        // Reset in the middle of a DMA
        repeat (20) @(posedge clk);
        trigger(8'h03, 1'b1);
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_rdy", 0, 32'(rdy_w[0]), 32'd1);
        chk("rst_active", 0, 32'(act_w[0]), 32'd0);
        chk("rst_read", 0, 32'(bus_rd_w[0]), 32'd0);
        chk("rst_write", 0, 32'(bus_wr_w[0]), 32'd0);
        cpu_rd = 1'b1; cpu_addr = 16'h1234;
        @(negedge clk);
        chk("rst_pt_read", 0, 32'(bus_rd_w[0]), 32'd1);
        chk("rst_pt_addr", 0, 32'(bus_addr_w[0]), 32'h1234);
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_addr = '0;

        // Fresh DMA after the abort starts from index 0
        trigger(8'h04, 1'b0);
        measure(0, c0, f0, l0);
        chk("post_rst_len", 0, 32'(c0), 32'd514);
        chk("post_rst_first", 0, 32'(f0), 32'h0400);

        repeat (10) @(posedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
